// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver with full frame checking, E0/F0
// prefix decoding and a first-word-fall-through event FIFO.
//
// Handshake: the head event (evt_code/evt_ext/evt_break) is valid while
// evt_valid=1 and holds steady until the cycle in which evt_valid and
// evt_ready are both high; that cycle's rising clk edge pops it.
//
// state_dbg exposes the frame FSM state (0=IDLE 1=DATA 2=PARITY 3=STOP).
module ps2_kbd_rx #(
  parameter int SYNC_STAGES  = 3,
  parameter int FIFO_DEPTH   = 8,
  parameter int TIMEOUT_CYC  = 50000,
  parameter int CHECK_PARITY = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic [7:0]                    evt_code,
  output logic                          evt_ext,
  output logic                          evt_break,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_err,
  input  logic                          err_clr,
  output logic [1:0]                    state_dbg
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic                   clk_s, data_s, neg;

  // Shift raw pins into the synchroniser chains
  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
    clk_prev_d = clk_sync_q[SYNC_STAGES-1];
  end

  // Synchroniser registers; idle-high so reset never fakes a falling edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      clk_prev_q <= clk_prev_d;
    end
  end

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = dat_sync_q[SYNC_STAGES-1];
  assign neg    = clk_prev_q & ~clk_s;

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            parity_q, parity_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic            byte_stb_q, byte_stb_d;
  logic [7:0]      byte_q, byte_d;
  logic            frame_err_q, frame_err_d;
  logic            parity_ok;

  // Odd parity across data and parity bit, or always accepted when disabled
  assign parity_ok = (CHECK_PARITY == 0) || (^{shreg_q, parity_q});

  // Next-state logic: advance on each ps2_clk falling edge, abort on timeout
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    parity_d    = parity_q;
    to_cnt_d    = to_cnt_q;
    byte_stb_d  = 1'b0;
    byte_d      = byte_q;
    frame_err_d = 1'b0;

    if (neg) begin
      to_cnt_d = '0;
      case (state_q)
        IDLE: begin
          if (!data_s) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        DATA: begin
          shreg_d[bit_cnt_q] = data_s;
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        PARITY: begin
          parity_d = data_s;
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (data_s && parity_ok) begin
            byte_stb_d = 1'b1;
            byte_d     = shreg_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (to_cnt_q == TO_LAST) begin
        // Host stopped clocking mid-frame: drop the partial byte
        state_d     = IDLE;
        to_cnt_d    = '0;
        frame_err_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  // Frame FSM registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shreg_q     <= 8'h00;
      parity_q    <= 1'b0;
      to_cnt_q    <= '0;
      byte_stb_q  <= 1'b0;
      byte_q      <= 8'h00;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      parity_q    <= parity_d;
      to_cnt_q    <= to_cnt_d;
      byte_stb_q  <= byte_stb_d;
      byte_q      <= byte_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;
  assign state_dbg = state_q;

  // ---------------------------------------------------------------------
  // Prefix decoder
  // ---------------------------------------------------------------------
  logic       ext_pend_q, ext_pend_d;
  logic       brk_pend_q, brk_pend_d;
  logic       push_req;
  logic [9:0] push_evt;

  // Collect E0/F0 prefixes and emit one event per non-prefix byte
  always_comb begin
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    push_req   = 1'b0;
    push_evt   = {ext_pend_q, brk_pend_q, byte_q};
    if (frame_err_q) begin
      // A broken frame may have been the code a prefix belonged to
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end else if (byte_stb_q) begin
      if (byte_q == 8'hE0) begin
        ext_pend_d = 1'b1;
      end else if (byte_q == 8'hF0) begin
        brk_pend_d = 1'b1;
      end else begin
        push_req   = 1'b1;
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
      end
    end
  end

  // Prefix flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
    end else begin
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
    end
  end

  // ---------------------------------------------------------------------
  // Event FIFO (first-word fall-through, register storage)
  // ---------------------------------------------------------------------
  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [9:0]    mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          full, pop, do_push, ovf_set;

  assign full    = (count_q == FULL_CNT);
  assign pop     = evt_valid & evt_ready;
  // A pop in the same cycle frees the slot the push needs
  assign do_push = push_req & (~full | pop);
  assign ovf_set = push_req & full & ~pop;

  // FIFO pointer, count, storage and overflow update
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_evt;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A fresh drop wins over a clear in the same cycle
    if (ovf_set) begin
      overflow_d = 1'b1;
    end else if (err_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // FIFO registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 10'h000;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign evt_valid  = (count_q != '0);
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign evt_code   = mem_q[rd_ptr_q][7:0];
  assign evt_break  = mem_q[rd_ptr_q][8];
  assign evt_ext    = mem_q[rd_ptr_q][9];

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: directed, table-driven bench for ps2_kbd_rx.
module tb_ps2_kbd_rx;

  localparam int SYNC  = 3;
  localparam int DEPTH = 8;
  localparam int TO    = 300;
  localparam int HALF  = 8;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       ps2_clk, ps2_data;
  logic [7:0] evt_code;
  logic       evt_ext, evt_break, evt_valid, evt_ready;
  logic [3:0] fifo_count;
  logic       overflow, frame_err, err_clr;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  ps2_kbd_rx #(
    .SYNC_STAGES (SYNC),
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TO),
    .CHECK_PARITY(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .evt_code  (evt_code),
    .evt_ext   (evt_ext),
    .evt_break (evt_break),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .fifo_count(fifo_count),
    .overflow  (overflow),
    .frame_err (frame_err),
    .err_clr   (err_clr),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_err    = 0;
  int         err_cnt  = 0;
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];

  // Record every popped event and every frame_err pulse, away from the edge
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) got_q.push_back({evt_ext, evt_break, evt_code});
    if (rst_n && frame_err) err_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare the drained events against exp_q, element by element
  task automatic check_drain(input string name);
    check({name, "_size"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s_%0d", name, i), (i < got_q.size()) ? got_q[i] : 10'h3FF, exp_q[i]);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // ---------------- driver ----------------
  task automatic drive_bit(input logic b);
    ps2_data = b;
    cycles(HALF);
    ps2_clk = 1'b0;
    cycles(HALF);
    ps2_clk = 1'b1;
  endtask

  // mode 0: plain; 1: check 2-cycle latency after stop neg; 2: pop in push cycle
  task automatic send_frame(input logic [7:0] code, input logic bad_par, input int mode);
    logic [10:0] bits;
    logic        par;
    par  = ~(^code) ^ bad_par;
    bits = {1'b1, par, code, 1'b0};
    for (int i = 0; i < 10; i++) drive_bit(bits[i]);
    ps2_data = 1'b1;
    cycles(HALF);
    ps2_clk = 1'b0;
    for (int k = 1; k <= HALF; k++) begin
      @(posedge clk);
      #1;
      if (mode == 1 && k == SYNC + 1) check("lat_not_yet", evt_valid, 1'b0);
      if (mode == 1 && k == SYNC + 2) begin
        check("lat_valid", evt_valid, 1'b1);
        check("lat_code", {evt_ext, evt_break, evt_code}, {2'b00, code});
      end
      #1;
      if (mode == 2 && k == SYNC + 1) evt_ready = 1'b1;
      if (mode == 2 && k == SYNC + 2) evt_ready = 1'b0;
    end
    ps2_clk = 1'b1;
    cycles(HALF);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] code;
    logic       bad_par;
    logic       exp_push;
    logic [9:0] exp_evt;
    int         exp_err;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{8'h1C, 1'b0, 1'b1, {2'b00, 8'h1C}, 0};
    vecs[1]  = '{8'hF0, 1'b0, 1'b0, 10'h000,         0};
    vecs[2]  = '{8'h1C, 1'b0, 1'b1, {2'b01, 8'h1C}, 0};
    vecs[3]  = '{8'hE0, 1'b0, 1'b0, 10'h000,         0};
    vecs[4]  = '{8'hF0, 1'b0, 1'b0, 10'h000,         0};
    vecs[5]  = '{8'h75, 1'b0, 1'b1, {2'b11, 8'h75}, 0};
    vecs[6]  = '{8'hE0, 1'b1, 1'b0, 10'h000,         1};
    vecs[7]  = '{8'h1C, 1'b0, 1'b1, {2'b00, 8'h1C}, 0};
    vecs[8]  = '{8'hE0, 1'b0, 1'b0, 10'h000,         0};
    vecs[9]  = '{8'h5A, 1'b1, 1'b0, 10'h000,         1};
    vecs[10] = '{8'h5A, 1'b0, 1'b1, {2'b00, 8'h5A}, 0};
    vecs[11] = '{8'hF0, 1'b0, 1'b0, 10'h000,         0};
    vecs[12] = '{8'hE0, 1'b0, 1'b0, 10'h000,         0};
    vecs[13] = '{8'h6B, 1'b0, 1'b1, {2'b11, 8'h6B}, 0};

    rst_n     = 1'b0;
    ps2_clk   = 1'b1;
    ps2_data  = 1'b1;
    evt_ready = 1'b0;
    err_clr   = 1'b0;
    cycles(4);
    check("rst_valid", evt_valid, 1'b0);
    check("rst_count", fifo_count, 4'd0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_head", {evt_ext, evt_break, evt_code}, 10'h000);
    check("rst_state", state_dbg, 2'd0);
    rst_n = 1'b1;
    cycles(4);

    // First frame: exact latency from the stop-bit edge
    evt_ready = 1'b1;
    got_q.delete();
    send_frame(8'h1C, 1'b0, 1);
    cycles(4);
    check("lat_one_event", got_q.size(), 1);

    // Lone clock pulse with data high is not a start bit
    err_cnt = 0;
    drive_bit(1'b1);
    cycles(6);
    check("nostart_err", err_cnt, 1);
    check("nostart_state", state_dbg, 2'd0);

    // Table of single frames, consumer always ready
    for (int v = 0; v < 14; v++) begin
      got_q.delete();
      err_cnt = 0;
      send_frame(vecs[v].code, vecs[v].bad_par, 0);
      cycles(10);
      check($sformatf("vec%0d_events", v), got_q.size(), {31'd0, vecs[v].exp_push});
      if (vecs[v].exp_push)
        check($sformatf("vec%0d_evt", v), (got_q.size() > 0) ? got_q[0] : 10'h3FF, vecs[v].exp_evt);
      check($sformatf("vec%0d_err", v), err_cnt, vecs[v].exp_err);
    end

    // Overflow: nine codes into an eight-deep FIFO with no consumer
    evt_ready = 1'b0;
    got_q.delete();
    for (int c = 1; c <= 9; c++) send_frame(8'(c), 1'b0, 0);
    cycles(5);
    check("ovf_count", fifo_count, 4'd8);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_head_stable", evt_code, 8'h01);
    evt_ready = 1'b1;
    cycles(12);
    evt_ready = 1'b0;
    exp_q.delete();
    for (int c = 1; c <= 8; c++) exp_q.push_back({2'b00, 8'(c)});
    check_drain("ovf_drain");
    check("ovf_sticky", overflow, 1'b1);
    err_clr = 1'b1;
    cycles(1);
    err_clr = 1'b0;
    cycles(1);
    check("ovf_cleared", overflow, 1'b0);
    check("ovf_empty", evt_valid, 1'b0);

    // Timeout: stop clocking after start + 4 data bits
    evt_ready = 1'b1;
    got_q.delete();
    err_cnt = 0;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    cycles(4);
    check("to_mid_state", state_dbg, 2'd1);
    check("to_mid_err", err_cnt, 0);
    cycles(TO + 20);
    check("to_err", err_cnt, 1);
    check("to_state", state_dbg, 2'd0);
    check("to_no_event", got_q.size(), 0);
    send_frame(8'h2D, 1'b0, 0);
    cycles(10);
    exp_q.delete();
    exp_q.push_back({2'b00, 8'h2D});
    check_drain("to_after");

    // Full FIFO: pop lands in the same cycle as the new push
    evt_ready = 1'b0;
    got_q.delete();
    for (int c = 'h11; c <= 'h18; c++) send_frame(8'(c), 1'b0, 0);
    cycles(5);
    check("full_count", fifo_count, 4'd8);
    send_frame(8'h19, 1'b0, 2);
    cycles(3);
    check("full_pp_count", fifo_count, 4'd8);
    check("full_pp_ovf", overflow, 1'b0);
    evt_ready = 1'b1;
    cycles(12);
    exp_q.delete();
    for (int c = 'h11; c <= 'h19; c++) exp_q.push_back({2'b00, 8'(c)});
    check_drain("full_pp_drain");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
Parametrised PS/2 keyboard receiver that replaces the single-byte scanner.
- Full frame checking: start bit, odd parity, stop bit, and a mid-frame timeout.
- Decodes the E0 (extended) and F0 (break) prefixes into flags.
- Queues complete key events, both make and break, in a first-word-fall-through FIFO with a valid/ready handshake to downstream logic (display, game control).
- Sits between the board PS/2 pins and the application logic.

Parameters:
SYNC_STAGES, 3, ps2_clk/ps2_data synchroniser depth (>=2)
FIFO_DEPTH, 8, event FIFO entries (power of 2, >=2)
TIMEOUT_CYC, 50000, clk cycles with no ps2_clk falling edge before a partial frame is aborted
CHECK_PARITY, 1, 1 = frames with bad parity are dropped; 0 = parity ignored

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
ps2_clk  in  1  raw PS/2 clock pin
ps2_data  in  1  raw PS/2 data pin
evt_code  out  8  scan code of the head event
evt_ext  out  1  head event was E0-prefixed
evt_break  out  1  head event was F0-prefixed (key release)
evt_valid  out  1  FIFO non-empty
evt_ready  in  1  consumer accepts the head event
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held
overflow  out  1  sticky; an event was dropped because the FIFO was full
frame_err  out  1  one-cycle pulse on any rejected or aborted frame
err_clr  in  1  clears overflow

Behaviour:
Input synchronisation:
- Clock is clk; reset is rst_n, asynchronous, active-low.
- ps2_clk and ps2_data each pass through SYNC_STAGES flops; all stages reset to 1.
- neg = previous synced ps2_clk & ~current synced ps2_clk.

Frame FSM (states IDLE, DATA, PARITY, STOP). Transitions occur only on cycles with neg=1, except the timeout.
- IDLE: data=0 -> DATA, bit_cnt=0. data=1 -> stay in IDLE and pulse frame_err.
- DATA: shift data into shreg[bit_cnt], LSB first. After bit 7 -> PARITY.
- PARITY: capture the parity bit -> STOP.
- STOP: the byte is good if data=1 and (CHECK_PARITY=0 or XOR(shreg, parity)=1). In both cases -> IDLE.
  - Good byte: byte_stb pulses one cycle later.
  - Bad byte: frame_err pulses.
- Timeout counter: clears on every neg and counts while not in IDLE. On reaching TIMEOUT_CYC-1 -> IDLE and pulse frame_err. No partial byte is ever emitted.

Prefix decoder (on byte_stb):
- E0 -> set ext_pend.
- F0 -> set brk_pend.
- Any other byte -> push {ext_pend, brk_pend, byte}, then clear both flags.
- A frame_err clears both flags. A stale prefix never attaches to a later code.

FIFO:
- Storage is registers, with wrap-around read/write pointers of width $clog2(FIFO_DEPTH).
- evt_valid = (count != 0). Head fields are driven from storage and are stable while valid=1 and ready=0.
- Pop occurs when evt_valid & evt_ready.
- Push when full without a pop: the event is dropped and overflow is set.
- Push and pop in the same cycle when full: both happen; count unchanged; no overflow.
- Push and pop in the same cycle when empty: push only.

Latency:
- Let the clk edge with neg=1 in STOP be edge N.
- byte_stb is high in cycle N+1, the FIFO write occurs at edge N+2, and evt_valid is high from cycle N+2.

Error flags:
- overflow clears on err_clr.
- If err_clr and a new overflow occur in the same cycle, overflow stays set.

Reset values:
- FSM = IDLE; count = 0; evt_valid, overflow and frame_err = 0.
- evt_code = 00; evt_ext = 0; evt_break = 0.
- Asserting rst_n low mid-frame discards the partial frame and all queued events immediately.

Test Plan:
- Send a valid frame 1C with evt_ready=1 -> one event: code=1C, ext=0, break=0. evt_valid rises exactly 2 cycles after the stop-bit neg.
- Send F0, 1C, then E0, F0, 75 -> two events: {1C, ext=0, break=1}, {75, ext=1, break=1}. No events for the prefix bytes.
- Send E0 with a corrupted parity bit, then 1C (CHECK_PARITY=1) -> frame_err pulses once. E0 is discarded, so the event is {1C, ext=0, break=0}.
- Hold evt_ready=0 and send 9 codes 01..09 -> fifo_count=8 and overflow=1. Draining yields 01..08 in order; 09 is absent. After err_clr, overflow=0.
- Stop ps2_clk after 4 data bits for TIMEOUT_CYC cycles -> frame_err pulse, FSM back in IDLE. A following frame 2D decodes correctly as {2D, 0, 0}.
- With the FIFO full, assert evt_ready and complete a new frame in the same cycle as the pop -> count stays 8, no overflow, and the new code is last in drain order.
